// File: rtl/lsu_sram.sv
// lsu_sram: load/store unit front-end for a single-ported 32-bit SRAM.
// Accepts byte/half/word loads and stores at any byte address. Accesses that
// cross a word boundary are split into two SRAM beats; the response carries
// the sign- or zero-extended load data, or an error for an illegal size.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_we, req_size,      store flag, size (00 byte, 01 half, 10 word, 11 illegal),
//   req_unsigned           zero-extend flag
//   req_addr, req_wdata    byte address, LSB-justified store data
//   rsp_valid/rsp_rdata/   one-cycle completion pulse, extended load data,
//   rsp_err                illegal-size flag
//   sram_cen/wen/ben       active-low chip, write and byte-lane enables
//   sram_addr, sram_din    word-aligned byte address, write data
//   sram_dout              read data, valid the cycle after a cen-low edge
module lsu_sram (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        sram_cen,
    output logic        sram_wen,
    output logic [3:0]  sram_ben,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_din,
    input  logic [31:0] sram_dout
);

    typedef enum logic {
        IDLE,
        BEAT1
    } state_t;

    state_t state, state_nxt;

    // Fields captured at acceptance
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_k;
    logic [31:0] r_addr;
    logic [31:0] r_din1;
    logic [3:0]  r_lanes1;
    logic        r_err;
    logic        r_split;
    logic [31:0] r_beat0;
    logic        rsp_valid_q;

    logic        accept;
    logic [1:0]  acc_k;
    logic [7:0]  acc_mask;
    logic [63:0] acc_place;
    logic        acc_split;
    logic        acc_illegal;

    logic [63:0] rd_pair;
    logic [31:0] rd_field;
    logic [31:0] rd_ext;

    // Lane mask across two adjacent words: bits 3:0 are beat 0, 7:4 beat 1.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] k);
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << k;
    endfunction

    assign acc_k       = req_addr[1:0];
    assign acc_mask    = lane_mask(req_size, acc_k);
    assign acc_place   = {32'b0, req_wdata} << {acc_k, 3'b000};
    assign acc_illegal = (req_size == 2'b11);
    assign acc_split   = (|acc_mask[7:4]) && !acc_illegal;
    assign accept      = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = (state == IDLE) && rst_n;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_ben  = '1;
        sram_addr = '0;
        sram_din  = '0;
        case (state)
            IDLE: begin
                // Beat 0 goes out in the same cycle the request is presented.
                if (req_valid && rst_n && !acc_illegal) begin
                    sram_cen  = 1'b0;
                    sram_wen  = !req_we;
                    sram_addr = {req_addr[31:2], 2'b00};
                    if (req_we) begin
                        sram_ben = ~acc_mask[3:0];
                        sram_din = acc_place[31:0];
                    end else begin
                        sram_ben = '0;
                    end
                end
                if (accept && acc_split) begin
                    state_nxt = BEAT1;
                end
            end
            BEAT1: begin
                sram_cen  = 1'b0;
                sram_wen  = !r_we;
                sram_addr = r_addr + 32'd4;
                if (r_we) begin
                    sram_ben = ~r_lanes1;
                    sram_din = r_din1;
                end else begin
                    sram_ben = '0;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_k         <= '0;
            r_addr      <= '0;
            r_din1      <= '0;
            r_lanes1    <= '0;
            r_err       <= 1'b0;
            r_split     <= 1'b0;
            r_beat0     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                r_we        <= req_we;
                r_size      <= req_size;
                r_unsigned  <= req_unsigned;
                r_k         <= acc_k;
                r_addr      <= {req_addr[31:2], 2'b00};
                r_din1      <= acc_place[63:32];
                r_lanes1    <= acc_mask[7:4];
                r_err       <= acc_illegal;
                r_split     <= acc_split;
                rsp_valid_q <= !acc_split;
            end
            if (state == BEAT1) begin
                r_beat0     <= sram_dout;
                rsp_valid_q <= 1'b1;
            end
        end
    end

    // In the response cycle sram_dout holds the last beat; for a split access
    // the first beat was captured during BEAT1.
    assign rd_pair  = r_split ? {sram_dout, r_beat0} : {32'b0, sram_dout};
    assign rd_field = 32'(rd_pair >> {r_k, 3'b000});

    always_comb begin
        case (r_size)
            2'b00:   rd_ext = {{24{!r_unsigned && rd_field[7]}},  rd_field[7:0]};
            2'b01:   rd_ext = {{16{!r_unsigned && rd_field[15]}}, rd_field[15:0]};
            default: rd_ext = rd_field;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_valid_q && r_err;
    assign rsp_rdata = (rsp_valid_q && !r_we && !r_err) ? rd_ext : '0;

endmodule

// File: tb/tb_lsu_sram.sv
module tb_lsu_sram;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sram_cen;
    logic        sram_wen;
    logic [3:0]  sram_ben;
    logic [31:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    int total = 0;
    int bad   = 0;

    // SRAM model, 256 words indexed by address bits 9:2, plus a backdoor write port
    logic [31:0] mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_val;

    lsu_sram dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .sram_cen     (sram_cen),
        .sram_wen     (sram_wen),
        .sram_ben     (sram_ben),
        .sram_addr    (sram_addr),
        .sram_din     (sram_din),
        .sram_dout    (sram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_val;
        end
        if (!sram_cen) begin
            sram_dout <= mem[sram_addr[9:2]];
            if (!sram_wen) begin
                for (int i = 0; i < 4; i++) begin
                    if (!sram_ben[i]) begin
                        mem[sram_addr[9:2]][8*i +: 8] <= sram_din[8*i +: 8];
                    end
                end
            end
        end else begin
            sram_dout <= '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        bd_we  = 1'b1;
        bd_idx = idx;
        bd_val = val;
        @(negedge clk);
        bd_we  = 1'b0;
    endtask

    initial begin
        logic [1:0]  t_size [4];
        logic        t_uns  [4];
        logic [31:0] t_addr [4];
        logic [31:0] t_exp  [4];

        t_size = '{2'b00, 2'b00, 2'b01, 2'b01};
        t_uns  = '{1'b0, 1'b1, 1'b0, 1'b1};
        t_addr = '{32'h103, 32'h103, 32'h102, 32'h101};
        t_exp  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h0000FF7F};

        rst_n = 1'b0;
        bd_we = 1'b0;
        bd_idx = '0;
        bd_val = '0;
        drive(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);

        // Reset with a request pending: everything held idle
        repeat (2) @(negedge clk);
        #1;
        chk("rst ready", {31'b0, req_ready}, 32'd0);
        chk("rst cen", {31'b0, sram_cen}, 32'd1);
        chk("rst wen", {31'b0, sram_wen}, 32'd1);
        chk("rst ben", {28'b0, sram_ben}, 32'hF);
        chk("rst addr", sram_addr, 32'h0);
        chk("rst din", sram_din, 32'h0);
        chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post-rst ready", {31'b0, req_ready}, 32'd1);

        // Store word then load it back
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        #1;
        chk("sw cen", {31'b0, sram_cen}, 32'd0);
        chk("sw wen", {31'b0, sram_wen}, 32'd0);
        chk("sw ben", {28'b0, sram_ben}, 32'h0);
        chk("sw addr", sram_addr, 32'h100);
        chk("sw din", sram_din, 32'hDEADBEEF);
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h100, 32'h12345678);
        #1;
        chk("sw rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("sw rsp_rdata", rsp_rdata, 32'h0);
        chk("sw rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("lw cen", {31'b0, sram_cen}, 32'd0);
        chk("lw wen", {31'b0, sram_wen}, 32'd1);
        chk("lw ben", {28'b0, sram_ben}, 32'h0);
        chk("lw din", sram_din, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("lw rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("lw rdata", rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("lw rsp pulse", {31'b0, rsp_valid}, 32'd0);

        // Sub-word loads with extension, back-to-back
        poke(8'd64, 32'h80FF7F01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, t_size[i], t_uns[i], t_addr[i], 32'hCAFEF00D);
            #1;
            chk("sub cen", {31'b0, sram_cen}, 32'd0);
            chk("sub addr", sram_addr, 32'h100);
            if (i > 0) begin
                chk("sub rsp_valid", {31'b0, rsp_valid}, 32'd1);
                chk("sub rdata", rsp_rdata, t_exp[i-1]);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("sub rsp_valid last", {31'b0, rsp_valid}, 32'd1);
        chk("sub rdata last", rsp_rdata, t_exp[3]);

        // Misaligned word load split across two words
        poke(8'd64, 32'h44332211);
        poke(8'd65, 32'h88776655);
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        #1;
        chk("mlw b0 addr", sram_addr, 32'h100);
        chk("mlw b0 ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = 32'hFFFF0000;
        req_size = 2'b00;
        req_unsigned = 1'b1;
        #1;
        chk("mlw b1 ready", {31'b0, req_ready}, 32'd0);
        chk("mlw b1 cen", {31'b0, sram_cen}, 32'd0);
        chk("mlw b1 addr", sram_addr, 32'h104);
        chk("mlw b1 ben", {28'b0, sram_ben}, 32'h0);
        chk("mlw b1 rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("mlw rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("mlw rdata", rsp_rdata, 32'h55443322);
        chk("mlw ready", {31'b0, req_ready}, 32'd1);

        // Misaligned half store split across two words
        @(negedge clk);
        drive(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000BBAA);
        #1;
        chk("msh b0 addr", sram_addr, 32'h100);
        chk("msh b0 wen", {31'b0, sram_wen}, 32'd0);
        chk("msh b0 ben", {28'b0, sram_ben}, 32'h7);
        chk("msh b0 din", sram_din, 32'hAA000000);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'hFFFFFFFF;
        #1;
        chk("msh b1 addr", sram_addr, 32'h104);
        chk("msh b1 wen", {31'b0, sram_wen}, 32'd0);
        chk("msh b1 ben", {28'b0, sram_ben}, 32'hE);
        chk("msh b1 din", sram_din, 32'h000000BB);
        chk("msh b1 rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("msh rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("msh rdata", rsp_rdata, 32'h0);
        chk("msh rsp_err", {31'b0, rsp_err}, 32'd0);
        // Read back across the same boundary: words now AA332211 / 887766BB
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h103, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("msh readback valid", {31'b0, rsp_valid}, 32'd1);
        chk("msh readback", rsp_rdata, 32'h7766BBAA);

        // Split load at the top of the address space wraps to 0
        poke(8'd255, 32'h11223344);
        poke(8'd0, 32'hA5A55A5A);
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
        #1;
        chk("wrap b0 addr", sram_addr, 32'hFFFFFFFC);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("wrap b1 cen", {31'b0, sram_cen}, 32'd0);
        chk("wrap b1 addr", sram_addr, 32'h0);
        @(negedge clk);
        #1;
        chk("wrap rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("wrap rdata", rsp_rdata, 32'h5A5A1122);

        // Illegal size: no SRAM access, error response
        @(negedge clk);
        drive(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        #1;
        chk("ill cen", {31'b0, sram_cen}, 32'd1);
        chk("ill ben", {28'b0, sram_ben}, 32'hF);
        chk("ill addr", sram_addr, 32'h0);
        chk("ill ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("ill rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("ill rsp_err", {31'b0, rsp_err}, 32'd1);
        chk("ill rdata", rsp_rdata, 32'h0);
        chk("ill cen resp", {31'b0, sram_cen}, 32'd1);
        @(negedge clk);
        #1;
        chk("ill err clears", {31'b0, rsp_err}, 32'd0);
        chk("ill valid clears", {31'b0, rsp_valid}, 32'd0);

        // Reset during BEAT1 abandons the access
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("rstb1 beat1 cen", {31'b0, sram_cen}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstb1 cen", {31'b0, sram_cen}, 32'd1);
        chk("rstb1 ben", {28'b0, sram_ben}, 32'hF);
        chk("rstb1 ready", {31'b0, req_ready}, 32'd0);
        chk("rstb1 rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("rstb1 no rsp", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rstb1 ready after", {31'b0, req_ready}, 32'd1);
        chk("rstb1 cen after", {31'b0, sram_cen}, 32'd1);
        @(negedge clk);
        #1;
        chk("rstb1 still no rsp", {31'b0, rsp_valid}, 32'd0);
        drive(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
        #1;
        chk("rstb1 lw cen", {31'b0, sram_cen}, 32'd0);
        chk("rstb1 lw addr", sram_addr, 32'h104);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("rstb1 lw rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rstb1 lw rdata", rsp_rdata, 32'h887766BB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_sram.md
LSU_SRAM -- requirements
Module: lsu_sram

Interface
REQ-001 SHALL have parameter: none; all widths fixed (32-bit address/data, 4 byte lanes).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have req_valid  in  1  load/store request present.
REQ-005 SHALL have req_ready  out  1  request accepted when req_valid&req_ready at a rising edge.
REQ-006 SHALL have req_we  in  1  1=store, 0=load.
REQ-007 SHALL have req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have req_unsigned  in  1  1=zero-extend, 0=sign-extend load data.
REQ-009 SHALL have req_addr  in  32  byte address; req_wdata  in  32  store data, LSB-justified.
REQ-010 SHALL have rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  32  extended load data (0 for stores); rsp_err  out  1  illegal size.
REQ-011 SHALL have sram_cen, sram_wen  out  1  active-low chip/write enable; sram_ben  out  4  active-low byte-lane enables, bit i = lane i (bits 8i+7:8i).
REQ-012 SHALL have sram_addr  out  32  word-aligned byte address (bits 1:0 = 0); sram_din  out  32; sram_dout  in  32, valid the cycle after a cen-low edge, 0 otherwise.

Function
REQ-013 SHALL implement states IDLE and BEAT1; req_ready = 1 only in IDLE with rst_n high.
REQ-014 In IDLE with req_valid, SHALL drive beat-0 access combinationally in the same cycle: sram_cen=0, sram_addr={req_addr[31:2],2'b00}.
REQ-015 Idle drive (no access) SHALL be cen=1, wen=1, ben=4'b1111, addr=0, din=0.
REQ-016 Loads SHALL drive wen=1, ben=4'b0000; stores SHALL drive wen=0 and ben low only on written lanes.
REQ-017 Offset k=req_addr[1:0]; access SHALL split when k+bytes>4 (word k=1..3, half k=3); byte never splits.
REQ-018 Non-split: rsp_valid SHALL assert in the cycle after acceptance (latency 1); rdata = (sram_dout>>8k) truncated to size, then extended.
REQ-019 Split: next state BEAT1; in BEAT1 SHALL drive beat 1 at sram_addr=beat-0 address+4 (modulo 2^32, wraps to 0), lanes 0..(k+bytes-5), and capture sram_dout (beat-0 data); rsp_valid in the cycle after BEAT1 (latency 2); rdata = ({dout_beat1,dout_beat0}>>8k) truncated, extended.
REQ-020 Store data SHALL be placed as din=wdata<<8k for beat 0 and din=wdata>>8(4-k) for beat 1.
REQ-021 BEAT1 SHALL return to IDLE unconditionally; a new request MAY be accepted in the rsp_valid cycle (back-to-back aligned throughput 1/cycle).
REQ-022 Request fields SHALL be registered at acceptance; req_* changes after acceptance SHALL not affect the operation.
REQ-023 req_size=11 SHALL issue no SRAM access (cen stays 1), rsp_valid next cycle with rsp_err=1, rdata=0.
REQ-024 Stores SHALL complete with rsp_valid, rdata=0, rsp_err=0, at the same latency as loads.
REQ-025 rsp_err SHALL be 0 whenever rsp_valid is 0; no response backpressure.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0, SRAM idle drive per REQ-015.
REQ-027 Reset during BEAT1 or with a response pending SHALL abandon the operation: no beat 1, no rsp_valid; req_ready=1 the first cycle after rst_n rises.

Verification
REQ-028 Store word 0xDEADBEEF @0x100, then load word @0x100 -> store cycle cen=0 wen=0 ben=0000 din=0xDEADBEEF; load rsp_valid next cycle rdata=0xDEADBEEF.
REQ-029 mem[0x100]=0x80FF7F01: lb @0x103 -> 0xFFFFFF80; lbu @0x103 -> 0x00000080; lh @0x102 -> 0xFFFF80FF; lhu @0x101 -> 0x0000FF7F (no split).
REQ-030 mem[0x100]=0x44332211, mem[0x104]=0x88776655, lw @0x101 -> addr 0x100 then 0x104, req_ready low 1 cycle, rsp_valid at latency 2, rdata=0x55443322.
REQ-031 sh 0x0000BBAA @0x103 -> beat 0 addr 0x100 ben=0111 din[31:24]=0xAA; beat 1 addr 0x104 ben=1110 din[7:0]=0xBB; rsp_valid latency 2.
REQ-032 lw @0xFFFFFFFE -> beat 1 addr 0x00000000; req_size=11 -> cen never low, rsp_valid+rsp_err, rdata=0.
REQ-033 Assert rst_n low during BEAT1 -> cen=1 same cycle, no rsp_valid; after release req_ready=1 and aligned lw succeeds.
